pc_fetch_unit: RTL and testbench

Sequential consumer of the combinational next-PC computation. It holds the architectural program counter, fetches the instruction at CurrentPC from instruction memory over a req/ack handshake, and presents it downstream over a valid/ready handshake. It then waits for the execute stage to retire the instruction, and on retirement loads the supplied NextPC and starts the next fetch. It is the multi-cycle PC register and fetch front end of the LEGv8 datapath.

---
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between pc_fetch_unit (master) and memory (slave).
// IMemReq is held high until the cycle IMemAck is seen; IMemData is captured
// in that same cycle. IMemAck while IMemReq=0 carries no meaning.
interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: multi-cycle PC register and fetch front end of the LEGv8 datapath.
// Holds CurrentPC, fetches over the imem req/ack bus, presents the instruction
// downstream, waits for retirement (PCUpdate) and loads NextPC verbatim.
// Optional macro PC_FETCH_STATS_EN adds RetireCount and TakenCount outputs.
//
// Downstream handshake: InstrValid=1 means Instr holds a fetched word not yet
// accepted; a transfer happens on a rising edge where InstrValid && InstrReady.
// InstrValid never drops without that transfer (except on reset), and Instr is
// stable while InstrValid is high. InstrReady with InstrValid=0 is ignored.
module pc_fetch_unit #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic [ADDR_W-1:0]   StartPC,
    input  logic [ADDR_W-1:0]   NextPC,
    input  logic                PCUpdate,
    pc_fetch_unit_if.master     imem,
    output logic                InstrValid,
    output logic [INSTR_W-1:0]  Instr,
    input  logic                InstrReady,
    output logic [ADDR_W-1:0]   CurrentPC,
    output logic                Misaligned,
`ifdef PC_FETCH_STATS_EN
    output logic [31:0]         RetireCount,
    output logic [31:0]         TakenCount,
`endif
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_VALID = 3'd2,
        S_EXEC  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_imem_req;
    logic               r_instr_valid;
    logic               r_misaligned;
    logic               w_retire;

    // A retirement is only accepted while waiting in S_EXEC.
    assign w_retire = (r_state == S_EXEC) && PCUpdate;

    // Fetch FSM; outputs are registered alongside the state so they follow it exactly.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_state       <= S_BOOT;
            r_pc          <= StartPC;
            r_instr       <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (r_pc[1:0] != 2'b00) begin
                        r_state      <= S_FAULT;
                        r_misaligned <= 1'b1;
                    end else begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem.IMemAck) begin
                        r_instr       <= imem.IMemData;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (InstrReady) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (PCUpdate) begin
                        // The PC loads even when it is misaligned, so the fault address is visible.
                        r_pc <= NextPC;
                        if (NextPC[1:0] != 2'b00) begin
                            r_state      <= S_FAULT;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    // Absorbing until reset.
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_misaligned  <= 1'b1;
                end
                default: begin
                    r_state       <= S_FAULT;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_misaligned  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_FETCH_STATS_EN
    logic [31:0]       r_retire_cnt;
    logic [31:0]       r_taken_cnt;
    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    // Retirement and taken-flow counters; both wrap naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_retire_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
            if (NextPC != w_pc_plus4) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign RetireCount = r_retire_cnt;
    assign TakenCount  = r_taken_cnt;
`else
    logic w_retire_unused;
    assign w_retire_unused = w_retire;
`endif

    assign imem.IMemReq  = r_imem_req;
    assign imem.IMemAddr = r_pc;
    assign InstrValid    = r_instr_valid;
    assign Instr         = r_instr;
    assign CurrentPC     = r_pc;
    assign Misaligned    = r_misaligned;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequential flow, taken branch,
// wait states, backpressure, misalignment faults and reset mid-fetch.
module tb_pc_fetch_unit;

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_VALID = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic        CLK;
    logic        Reset_L;
    logic [63:0] StartPC;
    logic [63:0] NextPC;
    logic        PCUpdate;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        InstrReady;
    logic [63:0] CurrentPC;
    logic        Misaligned;
    logic [2:0]  dbg_state;
`ifdef PC_FETCH_STATS_EN
    logic [31:0] RetireCount;
    logic [31:0] TakenCount;
`endif

    int errors = 0;
    int checks = 0;

    pc_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) imem_if ();

    pc_fetch_unit #(.ADDR_W(64), .INSTR_W(32)) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .StartPC     (StartPC),
        .NextPC      (NextPC),
        .PCUpdate    (PCUpdate),
        .imem        (imem_if.master),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .InstrReady  (InstrReady),
        .CurrentPC   (CurrentPC),
        .Misaligned  (Misaligned),
`ifdef PC_FETCH_STATS_EN
        .RetireCount (RetireCount),
        .TakenCount  (TakenCount),
`endif
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch from S_REQ, then accept and land in S_EXEC.
    task automatic fetch_and_accept(input logic [63:0] addr, input logic [31:0] word);
        chk("fetch_state_req", {61'd0, dbg_state}, {61'd0, S_REQ});
        chk("fetch_req", {63'd0, imem_if.IMemReq}, 64'd1);
        chk("fetch_addr", imem_if.IMemAddr, addr);
        imem_if.IMemAck  = 1'b1;
        imem_if.IMemData = word;
        tick();
        imem_if.IMemAck  = 1'b0;
        chk("fetch_valid", {63'd0, InstrValid}, 64'd1);
        chk("fetch_instr", {32'd0, Instr}, {32'd0, word});
        chk("fetch_req_drop", {63'd0, imem_if.IMemReq}, 64'd0);
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        chk("exec_state", {61'd0, dbg_state}, {61'd0, S_EXEC});
        chk("exec_valid_low", {63'd0, InstrValid}, 64'd0);
    endtask

    // Retire with the given NextPC from S_EXEC.
    task automatic retire(input logic [63:0] npc);
        NextPC   = npc;
        PCUpdate = 1'b1;
        tick();
        PCUpdate = 1'b0;
        chk("retire_pc", CurrentPC, npc);
    endtask

    initial begin
        Reset_L          = 1'b0;
        StartPC          = 64'h100;
        NextPC           = 64'h0;
        PCUpdate         = 1'b0;
        InstrReady       = 1'b0;
        imem_if.IMemAck  = 1'b0;
        imem_if.IMemData = 32'h0;

        // Reset state
        tick();
        chk("rst_pc", CurrentPC, 64'h100);
        chk("rst_req", {63'd0, imem_if.IMemReq}, 64'd0);
        chk("rst_valid", {63'd0, InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, Instr}, 64'd0);
        chk("rst_mis", {63'd0, Misaligned}, 64'd0);
        chk("rst_state", {61'd0, dbg_state}, {61'd0, S_BOOT});
`ifdef PC_FETCH_STATS_EN
        chk("rst_retire", {32'd0, RetireCount}, 64'd0);
        chk("rst_taken", {32'd0, TakenCount}, 64'd0);
`endif
        Reset_L = 1'b1;
        tick();
        // First fetch at 0x100
        fetch_and_accept(64'h100, 32'h8B020020);

        // Sequential run 0x104, 0x108, 0x10C
        retire(64'h104);
        fetch_and_accept(64'h104, 32'h91001021);
        retire(64'h108);
        fetch_and_accept(64'h108, 32'hCB020020);
        retire(64'h10C);
`ifdef PC_FETCH_STATS_EN
        chk("seq_retire", {32'd0, RetireCount}, 64'd3);
        chk("seq_taken", {32'd0, TakenCount}, 64'd0);
`endif
        fetch_and_accept(64'h10C, 32'hB4000040);

        // Taken branch backwards to 0x0F8
        retire(64'h0F8);
`ifdef PC_FETCH_STATS_EN
        chk("br_retire", {32'd0, RetireCount}, 64'd4);
        chk("br_taken", {32'd0, TakenCount}, 64'd1);
`endif

        // Wait states: no ack for 3 cycles, stray PCUpdate must be ignored
        NextPC   = 64'h200;
        PCUpdate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req_high", {63'd0, imem_if.IMemReq}, 64'd1);
            chk("ws_addr", imem_if.IMemAddr, 64'h0F8);
            chk("ws_state", {61'd0, dbg_state}, {61'd0, S_REQ});
            tick();
        end
        chk("ws_req_high_last", {63'd0, imem_if.IMemReq}, 64'd1);
        chk("ws_pc_hold", CurrentPC, 64'h0F8);
        imem_if.IMemAck  = 1'b1;
        imem_if.IMemData = 32'hD2800000;
        tick();
        imem_if.IMemAck  = 1'b0;
        imem_if.IMemData = 32'h12345678;
        chk("ws_req_drop", {63'd0, imem_if.IMemReq}, 64'd0);

        // Backpressure: InstrReady low for 4 cycles
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {63'd0, InstrValid}, 64'd1);
            chk("bp_instr", {32'd0, Instr}, {32'd0, 32'hD2800000});
            chk("bp_pc_hold", CurrentPC, 64'h0F8);
            tick();
        end
        PCUpdate   = 1'b0;
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        chk("bp_exec", {61'd0, dbg_state}, {61'd0, S_EXEC});
        chk("bp_pc_after", CurrentPC, 64'h0F8);

        // Ack with no request in S_EXEC is ignored
        imem_if.IMemAck  = 1'b1;
        imem_if.IMemData = 32'hFFFFFFFF;
        tick();
        imem_if.IMemAck  = 1'b0;
        chk("stray_ack_state", {61'd0, dbg_state}, {61'd0, S_EXEC});
        chk("stray_ack_instr", {32'd0, Instr}, {32'd0, 32'hD2800000});

        // Misaligned NextPC faults; PC still loads
        retire(64'h10A);
        chk("fault_mis", {63'd0, Misaligned}, 64'd1);
        chk("fault_state", {61'd0, dbg_state}, {61'd0, S_FAULT});
`ifdef PC_FETCH_STATS_EN
        chk("fault_retire", {32'd0, RetireCount}, 64'd5);
        chk("fault_taken", {32'd0, TakenCount}, 64'd2);
`endif
        imem_if.IMemAck = 1'b1;
        InstrReady      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("fault_req_low", {63'd0, imem_if.IMemReq}, 64'd0);
            chk("fault_sticky", {63'd0, Misaligned}, 64'd1);
        end
        imem_if.IMemAck = 1'b0;
        InstrReady      = 1'b0;
        chk("fault_pc", CurrentPC, 64'h10A);

        // Reset mid-fetch with a same-cycle ack
        StartPC = 64'h200;
        Reset_L = 1'b0;
        tick();
        chk("rst2_mis_clear", {63'd0, Misaligned}, 64'd0);
        Reset_L = 1'b1;
        tick();
        chk("rst2_req", {63'd0, imem_if.IMemReq}, 64'd1);
        chk("rst2_addr", imem_if.IMemAddr, 64'h200);
        StartPC          = 64'h300;
        Reset_L          = 1'b0;
        imem_if.IMemAck  = 1'b1;
        imem_if.IMemData = 32'hFFFFFFFF;
        tick();
        imem_if.IMemAck  = 1'b0;
        chk("midrst_instr", {32'd0, Instr}, 64'd0);
        chk("midrst_valid", {63'd0, InstrValid}, 64'd0);
        chk("midrst_req", {63'd0, imem_if.IMemReq}, 64'd0);
        chk("midrst_state", {61'd0, dbg_state}, {61'd0, S_BOOT});
        chk("midrst_pc", CurrentPC, 64'h300);
`ifdef PC_FETCH_STATS_EN
        chk("midrst_retire", {32'd0, RetireCount}, 64'd0);
`endif

        // Address wrap: 0xFFFF_FFFF_FFFF_FFFC -> 0 accepted verbatim
        StartPC = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        Reset_L = 1'b1;
        tick();
        fetch_and_accept(64'hFFFF_FFFF_FFFF_FFFC, 32'h17FFFFFF);
        retire(64'h0);
        chk("wrap_state", {61'd0, dbg_state}, {61'd0, S_REQ});
        chk("wrap_addr", imem_if.IMemAddr, 64'h0);
`ifdef PC_FETCH_STATS_EN
        chk("wrap_retire", {32'd0, RetireCount}, 64'd1);
        chk("wrap_taken", {32'd0, TakenCount}, 64'd0);
`endif

        // Misaligned StartPC faults out of S_BOOT with no fetch
        StartPC = 64'h3;
        Reset_L = 1'b0;
        tick();
        chk("boot3_pc", CurrentPC, 64'h3);
        Reset_L = 1'b1;
        tick();
        chk("boot3_mis", {63'd0, Misaligned}, 64'd1);
        chk("boot3_state", {61'd0, dbg_state}, {61'd0, S_FAULT});
        for (int i = 0; i < 5; i++) begin
            chk("boot3_req_low", {63'd0, imem_if.IMemReq}, 64'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
